// File: rtl/instr_decode_pipe.sv
// RV32I (+ optional RV32M) decode stage with a DEPTH-entry output queue.
// Latency: an instruction accepted in cycle N is at the head in cycle N+1 when the queue is empty.
// Backpressure: in_ready depends only on the registered count and flush, never on out_ready; a full queue blocks push even in a pop cycle.
//
// Optional feature macro: DECODE_RV32M_EN adds MUL..REMU ALU ops (ALU_OPS=22 instead of 14).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   fetch handshake; in_instr/in_pc are the instruction and its PC
//   flush               drops every queued entry and the instruction offered this cycle
//   out_valid/out_ready execute handshake on the queue head
//   out_pc, out_rs1/rs2/rd, out_rd_we, out_imm, out_funct3, out_alu_op,
//   out_opcode_type, out_exception   decoded head payload
//   out_rs1_raw/out_rs2_raw          combinational register fields of in_instr
module instr_decode_pipe #(
  parameter int XLEN          = 32,
  parameter int DEPTH         = 2,
  parameter int STRICT_DECODE = 1,
`ifdef DECODE_RV32M_EN
  localparam int ALU_OPS      = 22
`else
  localparam int ALU_OPS      = 14
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs1_raw,
  output logic [4:0]         out_rs2_raw,
  output logic               out_rd_we,
  output logic [XLEN-1:0]    out_imm,
  output logic [2:0]         out_funct3,
  output logic [ALU_OPS-1:0] out_alu_op,
  output logic [10:0]        out_opcode_type,
  output logic [3:0]         out_exception
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4, A_OR = 5, A_AND = 6;
  localparam int A_SLL = 7, A_SRL = 8, A_SRA = 9, A_EQ = 10, A_NEQ = 11, A_GE = 12, A_GEU = 13;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               rd_we;
    logic [XLEN-1:0]    imm;
    logic [2:0]         funct3;
    logic [ALU_OPS-1:0] alu_op;
    logic [10:0]        opcode_type;
    logic [3:0]         exception;
  } entry_t;

  entry_t            queue_q [DEPTH];
  entry_t            queue_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  entry_t            dec;
  logic              push, pop;

  // ---------------- combinational decode of in_instr ----------------
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd_f, rs1_f;
  logic       illegal, ecall, ebreak, mret, we_base, m_op;

  function automatic logic [ALU_OPS-1:0] base_alu(input logic [2:0] fn, input logic alt, input logic allow_sub);
    logic [ALU_OPS-1:0] v;
    v = '0;
    case (fn)
      3'd0:    v[(allow_sub && alt) ? A_SUB : A_ADD] = 1'b1;
      3'd1:    v[A_SLL]  = 1'b1;
      3'd2:    v[A_SLT]  = 1'b1;
      3'd3:    v[A_SLTU] = 1'b1;
      3'd4:    v[A_XOR]  = 1'b1;
      3'd5:    v[alt ? A_SRA : A_SRL] = 1'b1;
      3'd6:    v[A_OR]   = 1'b1;
      default: v[A_AND]  = 1'b1;
    endcase
    return v;
  endfunction

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign rd_f  = in_instr[11:7];
  assign rs1_f = in_instr[19:15];
`ifdef DECODE_RV32M_EN
  assign m_op  = (f7 == 7'b0000001);
`else
  assign m_op  = 1'b0;
`endif

  always_comb begin
    dec             = '0;
    illegal         = 1'b0;
    ecall           = 1'b0;
    ebreak          = 1'b0;
    mret            = 1'b0;
    we_base         = 1'b0;
    dec.pc          = in_pc;
    dec.rs1         = rs1_f;
    dec.rs2         = in_instr[24:20];
    dec.rd          = rd_f;
    dec.funct3      = f3;
    dec.alu_op[A_ADD] = 1'b1;
    case (opc)
      7'b0110011: begin
        dec.opcode_type[0] = 1'b1;
        we_base            = 1'b1;
        dec.alu_op         = base_alu(f3, in_instr[30], 1'b1);
`ifdef DECODE_RV32M_EN
        if (m_op) dec.alu_op = ALU_OPS'(1) << (14 + int'(f3));
`endif
        if (STRICT_DECODE != 0 && !(f7 == 7'd0 || m_op ||
            (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)))) illegal = 1'b1;
      end
      7'b0010011: begin
        dec.opcode_type[1] = 1'b1;
        we_base            = 1'b1;
        dec.imm            = XLEN'($signed(in_instr[31:20]));
        dec.alu_op         = base_alu(f3, in_instr[30], 1'b0);
        if (f3 == 3'd1 || f3 == 3'd5) begin
          // bit 25 would be shamt[5], which does not exist on RV32
          if (in_instr[25]) illegal = 1'b1;
          if (STRICT_DECODE != 0 && !(f7 == 7'd0 || (f3 == 3'd5 && f7 == 7'b0100000))) illegal = 1'b1;
        end
      end
      7'b0000011: begin
        dec.opcode_type[2] = 1'b1;
        we_base            = 1'b1;
        dec.imm            = XLEN'($signed(in_instr[31:20]));
        if (STRICT_DECODE != 0 && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) illegal = 1'b1;
      end
      7'b0100011: begin
        dec.opcode_type[3] = 1'b1;
        dec.imm            = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
        if (STRICT_DECODE != 0 && f3 > 3'd2) illegal = 1'b1;
      end
      7'b1100011: begin
        dec.opcode_type[4] = 1'b1;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
        dec.alu_op = '0;
        case (f3)
          3'd0:    dec.alu_op[A_EQ]   = 1'b1;
          3'd1:    dec.alu_op[A_NEQ]  = 1'b1;
          3'd4:    dec.alu_op[A_SLT]  = 1'b1;
          3'd5:    dec.alu_op[A_GE]   = 1'b1;
          3'd6:    dec.alu_op[A_SLTU] = 1'b1;
          3'd7:    dec.alu_op[A_GEU]  = 1'b1;
          default: begin
            dec.alu_op[A_ADD] = 1'b1;
            if (STRICT_DECODE != 0) illegal = 1'b1;
          end
        endcase
      end
      7'b1101111: begin
        dec.opcode_type[5] = 1'b1;
        we_base            = 1'b1;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
      end
      7'b1100111: begin
        dec.opcode_type[6] = 1'b1;
        we_base            = 1'b1;
        dec.imm            = XLEN'($signed(in_instr[31:20]));
        if (STRICT_DECODE != 0 && f3 != 3'd0) illegal = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        dec.opcode_type[opc[5] ? 7 : 8] = 1'b1;
        we_base = 1'b1;
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      7'b1110011: begin
        dec.opcode_type[9] = 1'b1;
        dec.imm            = XLEN'(in_instr[31:20]);
        if (f3 != 3'd0) begin
          we_base = 1'b1;
        end else if (STRICT_DECODE != 0 && (rs1_f != 5'd0 || rd_f != 5'd0)) begin
          illegal = 1'b1;
        end else begin
          case (in_instr[31:20])
            12'h000: ecall  = 1'b1;
            12'h001: ebreak = 1'b1;
            12'h302: mret   = 1'b1;
            default: if (STRICT_DECODE != 0) illegal = 1'b1;
          endcase
        end
      end
      7'b0001111: begin
        dec.opcode_type[10] = 1'b1;
        dec.imm             = XLEN'(in_instr[31:20]);
      end
      default: illegal = 1'b1;
    endcase
    // low bits != 2'b11 never match a listed opcode; kept explicit for clarity
    if (in_instr[1:0] != 2'b11) illegal = 1'b1;
    if (illegal) dec.alu_op = '0;
    dec.rd_we     = we_base && (rd_f != 5'd0) && !illegal;
    dec.exception = {mret, ebreak, ecall, illegal};
  end

  // ---------------- queue control ----------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = !rst && !flush && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    queue_d  = queue_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        queue_d[wr_ptr_q] = dec;
        wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      queue_q  <= queue_d;
    end
  end

  assign out_rs1_raw     = in_instr[19:15];
  assign out_rs2_raw     = in_instr[24:20];
  assign out_pc          = queue_q[rd_ptr_q].pc;
  assign out_rs1         = queue_q[rd_ptr_q].rs1;
  assign out_rs2         = queue_q[rd_ptr_q].rs2;
  assign out_rd          = queue_q[rd_ptr_q].rd;
  assign out_rd_we       = queue_q[rd_ptr_q].rd_we;
  assign out_imm         = queue_q[rd_ptr_q].imm;
  assign out_funct3      = queue_q[rd_ptr_q].funct3;
  assign out_alu_op      = queue_q[rd_ptr_q].alu_op;
  assign out_opcode_type = queue_q[rd_ptr_q].opcode_type;
  assign out_exception   = queue_q[rd_ptr_q].exception;

endmodule

// File: tb/tb_instr_decode_pipe.sv
module tb_instr_decode_pipe;
  localparam int XLEN = 32, DEPTH = 2, STRICT = 1;
`ifdef DECODE_RV32M_EN
  localparam int ALU_OPS = 22;
  localparam bit HAS_M   = 1'b1;
`else
  localparam int ALU_OPS = 14;
  localparam bit HAS_M   = 1'b0;
`endif

  logic clk, rst, in_valid, in_ready, flush, out_valid, out_ready, out_rd_we;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0] out_rs1, out_rs2, out_rd, out_rs1_raw, out_rs2_raw;
  logic [2:0] out_funct3;
  logic [ALU_OPS-1:0] out_alu_op;
  logic [10:0] out_opcode_type;
  logic [3:0] out_exception;

  instr_decode_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .STRICT_DECODE(STRICT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_raw(out_rs1_raw), .out_rs2_raw(out_rs2_raw), .out_rd_we(out_rd_we),
    .out_imm(out_imm), .out_funct3(out_funct3), .out_alu_op(out_alu_op),
    .out_opcode_type(out_opcode_type), .out_exception(out_exception));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0] rs1, rs2, rd;
    logic rd_we;
    logic [31:0] imm;
    logic [2:0] f3;
    logic [ALU_OPS-1:0] alu;
    logic [10:0] typ;
    logic [3:0] exc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // ALU op index from funct3 for register/immediate arithmetic
  function automatic int arith_idx(input int fn, input bit alt, input bit allow_sub);
    case (fn)
      0: return (allow_sub && alt) ? 1 : 0;
      1: return 7;
      2: return 2;
      3: return 3;
      4: return 4;
      5: return alt ? 9 : 8;
      6: return 5;
      default: return 6;
    endcase
  endfunction

  // Reference decoder: field arithmetic straight from the ISA encoding rules
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int t, a, f3, f7, imm12;
    bit ill, we;
    e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = ins[14:12];
    f3 = int'(ins[14:12]); f7 = int'(ins[31:25]); imm12 = int'(ins[31:20]);
    t = -1; a = 0; ill = 0; we = 0; e.imm = 0; e.exc = 0;
    case (int'(ins[6:0]))
      'h33: begin
        t = 0; we = 1;
        if (HAS_M && f7 == 1) a = 14 + f3;
        else begin
          a = arith_idx(f3, ins[30], 1);
          if (STRICT && !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)))) ill = 1;
        end
      end
      'h13: begin
        t = 1; we = 1; e.imm = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
        a = arith_idx(f3, ins[30], 0);
        if (f3 == 1 || f3 == 5) begin
          if (ins[25]) ill = 1;
          if (STRICT && !(f7 == 0 || (f3 == 5 && f7 == 32))) ill = 1;
        end
      end
      'h03: begin
        t = 2; we = 1; e.imm = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
        if (STRICT && (f3 == 3 || f3 == 6 || f3 == 7)) ill = 1;
      end
      'h23: begin
        t = 3; e.imm = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
        if (STRICT && f3 > 2) ill = 1;
      end
      'h63: begin
        t = 4;
        e.imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        case (f3)
          0: a = 10; 1: a = 11; 4: a = 2; 5: a = 12; 6: a = 3; 7: a = 13;
          default: begin a = 0; if (STRICT) ill = 1; end
        endcase
      end
      'h6f: begin
        t = 5; we = 1;
        e.imm = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      end
      'h67: begin
        t = 6; we = 1; e.imm = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
        if (STRICT && f3 != 0) ill = 1;
      end
      'h37: begin t = 7; we = 1; e.imm = ins & 32'hFFFF_F000; end
      'h17: begin t = 8; we = 1; e.imm = ins & 32'hFFFF_F000; end
      'h73: begin
        t = 9; e.imm = imm12;
        if (f3 != 0) we = 1;
        else if (STRICT && (ins[19:15] != 0 || ins[11:7] != 0)) ill = 1;
        else if (imm12 == 0) e.exc[1] = 1;
        else if (imm12 == 1) e.exc[2] = 1;
        else if (imm12 == 'h302) e.exc[3] = 1;
        else if (STRICT) ill = 1;
      end
      'h0f: begin t = 10; e.imm = imm12; end
      default: ill = 1;
    endcase
    e.exc[0] = ill;
    e.alu    = ill ? '0 : (ALU_OPS'(1) << a);
    e.typ    = (t >= 0) ? (11'd1 << t) : 11'd0;
    e.rd_we  = we && (ins[11:7] != 0) && !ill;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit held = 0;
  logic [31:0] held_pc, held_imm;
  logic [ALU_OPS-1:0] held_alu;

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst) begin
      chk("out_valid_vs_model", out_valid, exp_q.size() != 0);
      chk("in_ready_vs_model", in_ready, !flush && (exp_q.size() < DEPTH));
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_pc", out_pc, held_pc);
        chk("hold_imm", out_imm, held_imm);
        chk("hold_alu", out_alu_op, held_alu);
      end
    end
    @(negedge clk);
    held = 0;
    if (!rst && !flush && out_valid) begin
      if (!out_ready) begin
        held = 1; held_pc = out_pc; held_imm = out_imm; held_alu = out_alu_op;
      end else if (exp_q.size() == 0) begin
        chk("unexpected_output_pc", out_pc, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        chk("pc", out_pc, e.pc);
        chk("rs1", out_rs1, e.rs1);
        chk("rs2", out_rs2, e.rs2);
        chk("rd", out_rd, e.rd);
        chk("rd_we", out_rd_we, e.rd_we);
        chk("imm", out_imm, e.imm);
        chk("funct3", out_funct3, e.f3);
        chk("alu_op", out_alu_op, e.alu);
        chk("opcode_type", out_opcode_type, e.typ);
        chk("exception", out_exception, e.exc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl, output bit acc);
    @(posedge clk);
    #2;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    acc = 0;
    chk("rs1_raw", out_rs1_raw, ins[19:15]);
    if (fl) exp_q.delete();
    else if (v && in_ready) begin
      exp_q.push_back(ref_decode(ins, pc));
      acc = 1;
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    bit acc;
    acc = 0;
    for (int n = 0; n < 40 && !acc; n++) drive(1, ins, pc, 1, 0, acc);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    drive(0, 32'h0, 32'h0, ordy, 0, acc);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [6:0] ops [11];
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0f};
    r = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11) r[6:0] = ops[k];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    if (r[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
      r[14:12] = 3'd0; r[19:15] = 5'd0; r[11:7] = 5'd0;
      case ($urandom_range(0, 3))
        0: r[31:20] = 12'h000;
        1: r[31:20] = 12'h001;
        2: r[31:20] = 12'h302;
        default: ;
      endcase
    end
    return r;
  endfunction

  initial begin
    bit acc;
    bit [2:0] accs;
    rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_imm", out_imm, 0);
    chk("reset_out_alu", out_alu_op, 0);
    chk("reset_out_type", out_opcode_type, 0);
    @(posedge clk);
    #2;
    rst = 0;

    // addi x1,x0,5: visible the cycle after acceptance
    send(32'h0050_0093, 32'h100);
    idle(1);
    chk("t1_valid", out_valid, 1);
    chk("t1_rd", out_rd, 1);
    chk("t1_imm", out_imm, 5);
    chk("t1_alu_add", out_alu_op[0], 1);
    chk("t1_type_itype", out_opcode_type, 11'b10);
    chk("t1_rd_we", out_rd_we, 1);
    chk("t1_exc", out_exception, 0);

    // back-to-back add/sub/beq
    send(32'h0020_81B3, 32'h104);
    send(32'h4020_81B3, 32'h108);
    send(32'h0020_8463, 32'h10C);
    repeat (3) idle(1);

    // stall with DEPTH=2: third offer refused
    drive(1, 32'h0010_0113, 32'h200, 0, 0, acc); accs[0] = acc;
    drive(1, 32'h0020_0193, 32'h204, 0, 0, acc); accs[1] = acc;
    drive(1, 32'h0030_0213, 32'h208, 0, 0, acc); accs[2] = acc;
    chk("t3_accept_pattern", accs, 3'b011);
    repeat (3) idle(1);

    // flush with 2 queued entries and an incoming instruction
    drive(1, 32'h0050_0293, 32'h300, 0, 0, acc);
    drive(1, 32'h0060_0313, 32'h304, 0, 0, acc);
    drive(1, 32'h0070_0393, 32'h308, 1, 1, acc);
    chk("t4_flush_accept", acc, 0);
    idle(1);
    chk("t4_valid_after_flush", out_valid, 0);
    idle(1);

    // illegal shift, ecall, mret
    send(32'h0200_9093, 32'h400);
    idle(1);
    chk("t5_illegal", out_exception, 4'b0001);
    chk("t5_alu_zero", out_alu_op, 0);
    chk("t5_rd_we", out_rd_we, 0);
    send(32'h0000_0073, 32'h404);
    idle(1);
    chk("t5_ecall", out_exception, 4'b0010);
    send(32'h3020_0073, 32'h408);
    idle(1);
    chk("t5_mret", out_exception, 4'b1000);

    // mul x3,x1,x2
    send(32'h0220_81B3, 32'h500);
    idle(1);
    chk("t6_rd", out_rd, 3);
`ifdef DECODE_RV32M_EN
    chk("t6_mul", out_alu_op, ALU_OPS'(1) << 14);
`else
    chk("t6_illegal", out_exception[0], 1);
`endif

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, gen_instr(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, acc);
    end
    repeat (DEPTH + 2) idle(1);
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
